alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_seq.sv | 65 ++++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state definitions for alu_seq / alu_mul_seq.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Opcodes are the 5-bit concatenation {select, c_in}.
package alu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam logic [4:0] OP_PASS = 5'b0000_0;  // a
    localparam logic [4:0] OP_INC  = 5'b0000_1;  // a + 1
    localparam logic [4:0] OP_ADD  = 5'b0001_0;  // a + b
    localparam logic [4:0] OP_ADC  = 5'b0001_1;  // a + b + 1
    localparam logic [4:0] OP_SUBN = 5'b0010_0;  // a + ~b
    localparam logic [4:0] OP_SUB  = 5'b0010_1;  // a + ~b + 1
    localparam logic [4:0] OP_DEC  = 5'b0011_0;  // a - 1 (a + all-ones)
    localparam logic [4:0] OP_MOVB = 5'b0011_1;  // b
    localparam logic [4:0] OP_AND  = 5'b0100_0;
    localparam logic [4:0] OP_OR   = 5'b0101_0;
    localparam logic [4:0] OP_XOR  = 5'b0101_1;
    localparam logic [4:0] OP_NOT  = 5'b0110_0;
    localparam logic [4:0] OP_SHL  = 5'b0111_0;
    localparam logic [4:0] OP_SHR  = 5'b0111_1;
    localparam logic [4:0] OP_ZERO = 5'b1000_0;
    localparam logic [4:0] OP_MUL  = 5'b1001_0;

    // Opcodes whose carry (bit WIDTH of the result) is reported on flag_c.
    function automatic logic is_arith(input logic [4:0] op);
        return (op inside {OP_INC, OP_ADD, OP_ADC, OP_SUBN, OP_SUB, OP_DEC});
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
// Latency: WIDTH busy cycles after start; p is the final product while busy && done.
// Backpressure: none; start is only legal while idle, caller owns the result timing.
// Ports: clk, rst_n (async active-low), start (load operands), a/b operands,
//        busy (iterating), done (current step is the last one), p (accumulator after this step).
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_last;

    // The sum for the current step is exposed combinationally so the owner can
    // capture the product on the same edge that retires the last step.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    assign busy = r_busy;
    assign done = w_last;
    assign p    = w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and flags, optional sequential multiply.
// Latency: 1 edge for single-cycle opcodes, WIDTH+1 edges for multiply.
// Backpressure: result held while out_valid && !out_ready; in_ready low while stalled or multiplying.
// Ports: clk, rst_n (async active-low); request in_valid/in_ready with a, b, c_in, select;
//        result out_valid/out_ready with y (2*WIDTH), flag_z, flag_c, flag_err.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 c_in,
    input  logic [3:0]           select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_err
);

    state_t             r_state;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_y;
    logic               r_flag_z;
    logic               r_flag_c;
    logic               r_flag_err;

    logic [4:0]         w_op;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_err;
    logic               w_arith;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_b_ext;
    logic [WIDTH:0]     w_nb_ext;
    logic [WIDTH:0]     w_ones_ext;
    logic [WIDTH:0]     w_one_ext;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic               w_mul_fin;
    logic [2*WIDTH-1:0] w_mul_p;

    assign w_op       = {select, c_in};
    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;

    // Arithmetic runs at WIDTH+1 bits so bit WIDTH carries out into y and flag_c.
    // Decrement adds all-ones, so a=0 yields {0, all-ones} with no carry.
    assign w_a_ext    = {1'b0, a};
    assign w_b_ext    = {1'b0, b};
    assign w_nb_ext   = {1'b0, ~b};
    assign w_ones_ext = {1'b0, {WIDTH{1'b1}}};
    assign w_one_ext  = {{WIDTH{1'b0}}, 1'b1};
    assign w_arith    = is_arith(w_op);

    always_comb begin
        w_res    = '0;
        w_err    = 1'b0;
        w_is_mul = 1'b0;
        case (w_op)
            OP_PASS: w_res[WIDTH-1:0] = a;
            OP_INC:  w_res[WIDTH:0]   = w_a_ext + w_one_ext;
            OP_ADD:  w_res[WIDTH:0]   = w_a_ext + w_b_ext;
            OP_ADC:  w_res[WIDTH:0]   = w_a_ext + w_b_ext + w_one_ext;
            OP_SUBN: w_res[WIDTH:0]   = w_a_ext + w_nb_ext;
            OP_SUB:  w_res[WIDTH:0]   = w_a_ext + w_nb_ext + w_one_ext;
            OP_DEC:  w_res[WIDTH:0]   = w_a_ext + w_ones_ext;
            OP_MOVB: w_res[WIDTH-1:0] = b;
            OP_AND:  w_res[WIDTH-1:0] = a & b;
            OP_OR:   w_res[WIDTH-1:0] = a | b;
            OP_XOR:  w_res[WIDTH-1:0] = a ^ b;
            OP_NOT:  w_res[WIDTH-1:0] = ~a;
            OP_SHL:  w_res[WIDTH-1:0] = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  w_res[WIDTH-1:0] = {1'b0, a[WIDTH-1:1]};
            OP_ZERO: w_res            = '0;
            OP_MUL: begin
                if (MUL_EN != 0) begin
                    w_is_mul = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_mul_start = w_accept && w_is_mul;
    // done only marks the final step; it is meaningful while the multiplier is busy.
    assign w_mul_fin   = w_mul_busy && w_mul_done;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mul_start),
        .a     (a),
        .b     (b),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .p     (w_mul_p)
    );

    // One process owns the FSM and every registered output. A multiply finish and
    // a new acceptance never coincide because in_ready is low throughout ST_MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_err  <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_y         <= w_res;
            r_flag_z    <= (w_res == '0);
            r_flag_c    <= w_arith && w_res[WIDTH];
            r_flag_err  <= w_err;
        end else if ((r_state == ST_MUL) && w_mul_fin) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b1;
            r_y         <= w_mul_p;
            r_flag_z    <= (w_mul_p == '0);
            r_flag_c    <= 1'b0;
            r_flag_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= ST_MUL;
            end
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_err  = r_flag_err;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           c_in;
    logic [3:0]     select;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] y;
    logic           flag_z;
    logic           flag_c;
    logic           flag_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] y;
        logic        c;
        logic        err;
    } exp_t;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .select(select),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .flag_z(flag_z), .flag_c(flag_c), .flag_err(flag_err)
    );

    // Reference: the opcode table evaluated with plain integer arithmetic.
    function automatic exp_t ref_op(input int av, input int bv, input int ci, input int sel);
        exp_t e;
        int   r;
        int   mask;
        bit   arith;
        mask  = (1 << W) - 1;
        r     = 0;
        arith = 0;
        e.err = 1'b0;
        case (sel * 2 + ci)
            0:  r = av;
            1:  begin r = av + 1; arith = 1; end
            2:  begin r = av + bv; arith = 1; end
            3:  begin r = av + bv + 1; arith = 1; end
            4:  begin r = av + (mask - bv); arith = 1; end
            5:  begin r = av + (mask - bv) + 1; arith = 1; end
            6:  begin r = av + mask; arith = 1; end
            7:  r = bv;
            8:  r = av & bv;
            10: r = av | bv;
            11: r = av ^ bv;
            12: r = mask - av;
            14: r = (av * 2) & mask;
            15: r = av / 2;
            16: r = 0;
            18: r = av * bv;
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.y = 16'(r);
        e.c = arith ? r[W] : 1'b0;
        return e;
    endfunction

    // Drives one request, waits for its result; lat = edges from acceptance, -1 on timeout.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                         input logic [3:0] isel, output logic [15:0] oy, output logic oc,
                         output logic oz, output logic oerr, output int lat);
        int k;
        oy = '0; oc = 0; oz = 0; oerr = 0; lat = -1;
        a = ia; b = ib; c_in = ici; select = isel; in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(posedge clk); #1; @(negedge clk); k++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n; oy = y; oc = flag_c; oz = flag_z; oerr = flag_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; select = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (y !== '0) begin n_bad++; $display("FAIL reset_y got %h want 0000", y); end
        n_cmp++; if ({flag_z, flag_c, flag_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {flag_z, flag_c, flag_err}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci;
        logic [3:0]  sel;
        logic [15:0] y;
        logic        c;
        logic        z;
        logic        err;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[9];
        logic [15:0] gy; logic gc, gz, ge; int lat;
        tbl = '{
            '{8'hFF, 8'h01, 1'b0, 4'b0001, 16'h0100, 1'b1, 1'b0, 1'b0},
            '{8'h00, 8'h00, 1'b0, 4'b0011, 16'h00FF, 1'b0, 1'b0, 1'b0},
            '{8'h5A, 8'h33, 1'b0, 4'b1000, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{8'h80, 8'h00, 1'b0, 4'b0111, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{8'h81, 8'h00, 1'b1, 4'b0111, 16'h0040, 1'b0, 1'b0, 1'b0},
            '{8'h0F, 8'hF0, 1'b1, 4'b0101, 16'h00FF, 1'b0, 1'b0, 1'b0},
            '{8'h00, 8'hFF, 1'b0, 4'b0010, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{8'h05, 8'h03, 1'b1, 4'b0010, 16'h0102, 1'b1, 1'b0, 1'b0},
            '{8'h37, 8'hC8, 1'b1, 4'b1111, 16'h0000, 1'b0, 1'b1, 1'b1}
        };
        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sel, gy, gc, gz, ge, lat);
            n_cmp++;
            if (lat !== 1 || gy !== tbl[i].y || gc !== tbl[i].c || gz !== tbl[i].z || ge !== tbl[i].err) begin
                n_bad++;
                $display("FAIL directed[%0d] got y=%h c=%b z=%b err=%b lat=%0d want y=%h c=%b z=%b err=%b lat=1",
                         i, gy, gc, gz, ge, lat, tbl[i].y, tbl[i].c, tbl[i].z, tbl[i].err);
            end
        end
    endtask

    task automatic test_mul();
        a = 8'hFF; b = 8'hFF; c_in = 1'b0; select = 4'b1001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mul_accept in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL mul_busy cycle %0d got in_ready=%b out_valid=%b want 0 0", i, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || y !== 16'hFE01 || flag_c !== 1'b0 || flag_z !== 1'b0 || flag_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_result got v=%b y=%h c=%b z=%b err=%b want v=1 y=fe01 c=0 z=0 err=0",
                     out_valid, y, flag_c, flag_z, flag_err);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mul_done in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_random();
        logic [15:0] gy; logic gc, gz, ge; int lat;
        logic [7:0] ra, rb;
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = (i == 0) ? 8'h00 : 8'($urandom);
            do_op(ra, rb, 1'b0, 4'b1001, gy, gc, gz, ge, lat);
            n_cmp++;
            if (lat !== W + 1 || gy !== 16'(int'(ra) * int'(rb)) || gz !== (int'(ra) * int'(rb) == 0) || gc !== 1'b0 || ge !== 1'b0) begin
                n_bad++;
                $display("FAIL mul_rand %h*%h got y=%h z=%b c=%b err=%b lat=%0d want y=%h lat=%0d",
                         ra, rb, gy, gz, gc, ge, lat, 16'(int'(ra) * int'(rb)), W + 1);
            end
        end
    endtask

    task automatic test_stall();
        exp_t ex, ey;
        out_ready = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'b0; select = 4'b0001; in_valid = 1'b1;
        ex = ref_op(int'(a), int'(b), 0, 1);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_first in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'b1; select = 4'b0101;
        ey = ref_op(int'(a), int'(b), 1, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || y !== ex.y || flag_c !== ex.c || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold cycle %0d got v=%b y=%h c=%b in_ready=%b want v=1 y=%h c=%b in_ready=0",
                         i, out_valid, y, flag_c, in_ready, ex.y, ex.c);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || y !== ey.y || flag_err !== ey.err) begin
            n_bad++;
            $display("FAIL stall_next got v=%b y=%h err=%b want v=1 y=%h err=%b", out_valid, y, flag_err, ey.y, ey.err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        logic [4:0] code;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            code = 5'($urandom_range(0, 31));
            if (code == 5'd18) code = 5'd2;
            a = 8'($urandom); b = 8'($urandom); c_in = code[0]; select = code[4:1]; in_valid = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (!out_valid || q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_bubble cycle %0d got out_valid=%b want 1", i, out_valid);
                end else begin
                    e = q.pop_front();
                    if (y !== e.y || flag_c !== e.c || flag_err !== e.err || flag_z !== (e.y == 0)) begin
                        n_bad++;
                        $display("FAIL b2b_data cycle %0d got y=%h c=%b err=%b z=%b want y=%h c=%b err=%b",
                                 i, y, flag_c, flag_err, flag_z, e.y, e.c, e.err);
                    end
                end
            end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", i, in_ready); end
            q.push_back(ref_op(int'(a), int'(b), int'(c_in), int'(select)));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        e = q.pop_front();
        if (out_valid !== 1'b1 || y !== e.y) begin
            n_bad++;
            $display("FAIL b2b_last got v=%b y=%h want v=1 y=%h", out_valid, y, e.y);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic [4:0]  code;
        logic        have_snap;
        logic [15:0] snap_y;
        int          drain;
        have_snap = 1'b0; snap_y = '0;
        for (int i = 0; i < 400; i++) begin
            code = 5'($urandom_range(0, 31));
            a = 8'($urandom); b = 8'($urandom); c_in = code[0]; select = code[4:1];
            in_valid  = (i < 300) && ($urandom_range(0, 9) < 7);
            out_ready = (i >= 300) || ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (have_snap) begin
                n_cmp++;
                if (out_valid !== 1'b1 || y !== snap_y) begin
                    n_bad++;
                    $display("FAIL rand_hold cycle %0d got v=%b y=%h want v=1 y=%h", i, out_valid, y, snap_y);
                end
            end
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rand_stall_ready cycle %0d got %b want 0", i, in_ready); end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra cycle %0d got y=%h want no result", i, y);
                end else begin
                    e = q.pop_front();
                    if (y !== e.y || flag_c !== e.c || flag_err !== e.err || flag_z !== (e.y == 0)) begin
                        n_bad++;
                        $display("FAIL rand_data cycle %0d got y=%h c=%b err=%b z=%b want y=%h c=%b err=%b",
                                 i, y, flag_c, flag_err, flag_z, e.y, e.c, e.err);
                    end
                end
            end
            have_snap = out_valid && !out_ready;
            snap_y    = y;
            if (in_valid && in_ready) q.push_back(ref_op(int'(a), int'(b), int'(c_in), int'(select)));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain = q.size();
        n_cmp++;
        if (drain != 0) begin n_bad++; $display("FAIL rand_drain got %0d pending want 0", drain); end
    endtask

    task automatic test_abort();
        logic [15:0] gy; logic gc, gz, ge; int lat;
        do_op(8'h5A, 8'h00, 1'b0, 4'b0000, gy, gc, gz, ge, lat);
        n_cmp++; if (gy !== 16'h005A || lat !== 1) begin n_bad++; $display("FAIL abort_pre got y=%h lat=%0d want 005a 1", gy, lat); end
        a = 8'hC3; b = 8'h7E; c_in = 1'b0; select = 4'b1001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || y !== '0 || {flag_z, flag_c, flag_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_in_reset got v=%b y=%h flags=%b want v=0 y=0000 flags=000", out_valid, y, {flag_z, flag_c, flag_err});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_after cycle %0d got out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        do_op(8'h12, 8'h34, 1'b0, 4'b0001, gy, gc, gz, ge, lat);
        n_cmp++; if (gy !== 16'h0046 || lat !== 1) begin n_bad++; $display("FAIL abort_recover got y=%h lat=%0d want 0046 1", gy, lat); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_mul_random();
        test_stall();
        test_back_to_back();
        test_random();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
